// File: rtl/lab2_cmd_parser.sv
// lab2_cmd_parser: parses "HH op HH CR" ASCII commands from a UART byte
// stream, presents the two operands and the operation to an adder stage,
// and waits (with a timeout) for the adder's ready pulse.
module lab2_cmd_parser #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       Gl_rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  input  logic       adder_rdy,
  output logic [7:0] r1,
  output logic [7:0] r2,
  output logic       subtract,
  output logic       adder_start,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    A_HI, A_LO, OP, B_HI, B_LO, CR, START, WAIT
  } state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_CR    = 8'h0D;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_a_hi, r_a_lo, r_b_hi, r_b_lo;
  logic        r_op_sub;
  logic [7:0]  r_r1, r_r2;
  logic        r_sub;
  logic        r_err;
  logic [15:0] r_cnt;

  logic        w_hex_ok;
  logic [3:0]  w_nib;
  logic        w_ld_a_hi, w_ld_a_lo, w_ld_b_hi, w_ld_b_lo, w_ld_op;
  logic        w_load_out;
  logic        w_err_set;
  logic        w_timeout;

  assign w_timeout = (r_cnt == 16'(TIMEOUT - 1));

  // Decode the incoming byte as a hex digit (upper or lower case letters).
  always_comb begin
    w_hex_ok = 1'b0;
    w_nib    = '0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      w_hex_ok = 1'b1;
      w_nib    = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      w_hex_ok = 1'b1;
      w_nib    = rx_data[3:0] + 4'd9;
    end
  end

  // Next-state logic plus load/error strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_a_hi   = 1'b0;
    w_ld_a_lo   = 1'b0;
    w_ld_b_hi   = 1'b0;
    w_ld_b_lo   = 1'b0;
    w_ld_op     = 1'b0;
    w_load_out  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      START: w_state_nxt = WAIT;
      WAIT: begin
        // Ready takes priority over a coincident timeout.
        if (adder_rdy) begin
          w_state_nxt = A_HI;
        end else if (w_timeout) begin
          w_state_nxt = A_HI;
          w_err_set   = 1'b1;
        end
      end
      default: begin
        if (rx_vld && rx_data != CH_SPACE) begin
          if (rx_data == CH_ESC) begin
            w_state_nxt = A_HI;
          end else begin
            w_state_nxt = A_HI;
            w_err_set   = 1'b1;
            case (r_state)
              A_HI: if (w_hex_ok) begin
                w_ld_a_hi = 1'b1; w_err_set = 1'b0; w_state_nxt = A_LO;
              end
              A_LO: if (w_hex_ok) begin
                w_ld_a_lo = 1'b1; w_err_set = 1'b0; w_state_nxt = OP;
              end
              OP: if (rx_data == CH_PLUS || rx_data == CH_MINUS) begin
                w_ld_op = 1'b1; w_err_set = 1'b0; w_state_nxt = B_HI;
              end
              B_HI: if (w_hex_ok) begin
                w_ld_b_hi = 1'b1; w_err_set = 1'b0; w_state_nxt = B_LO;
              end
              B_LO: if (w_hex_ok) begin
                w_ld_b_lo = 1'b1; w_err_set = 1'b0; w_state_nxt = CR;
              end
              CR: if (rx_data == CH_CR) begin
                w_load_out = 1'b1; w_err_set = 1'b0; w_state_nxt = START;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge Gl_rst_n) begin
    if (!Gl_rst_n) r_state <= A_HI;
    else           r_state <= w_state_nxt;
  end

  // Nibble/op shadows, registered outputs, err pulse and WAIT counter.
  always_ff @(posedge clk or negedge Gl_rst_n) begin
    if (!Gl_rst_n) begin
      r_a_hi   <= '0;
      r_a_lo   <= '0;
      r_b_hi   <= '0;
      r_b_lo   <= '0;
      r_op_sub <= 1'b0;
      r_r1     <= '0;
      r_r2     <= '0;
      r_sub    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_ld_a_hi) r_a_hi   <= w_nib;
      if (w_ld_a_lo) r_a_lo   <= w_nib;
      if (w_ld_b_hi) r_b_hi   <= w_nib;
      if (w_ld_b_lo) r_b_lo   <= w_nib;
      if (w_ld_op)   r_op_sub <= (rx_data == CH_MINUS);
      if (w_load_out) begin
        r_r1  <= {r_a_hi, r_a_lo};
        r_r2  <= {r_b_hi, r_b_lo};
        r_sub <= r_op_sub;
      end
      r_err <= w_err_set;
      if (r_state == WAIT) r_cnt <= r_cnt + 16'd1;
      else                 r_cnt <= '0;
    end
  end

  assign r1          = r_r1;
  assign r2          = r_r2;
  assign subtract    = r_sub;
  assign err         = r_err;
  assign adder_start = (r_state == START);
  assign busy        = (r_state == START) || (r_state == WAIT);

endmodule

// File: doc/lab2_cmd_parser.md
LAB2_CMD_PARSER -- requirements
Module: lab2_cmd_parser

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum cycles to wait for adder ready (1..65535).
REQ-002 clk  input  1  single global clock; all state SHALL update on its rising edge.
REQ-003 Gl_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_data  input  8  ASCII byte from the UART receiver.
REQ-005 rx_vld  input  1  one-cycle strobe; rx_data is valid when high.
REQ-006 adder_rdy  input  1  ready pulse from the downstream adder stage.
REQ-007 r1  output  8  operand 1, registered.
REQ-008 r2  output  8  operand 2, registered.
REQ-009 subtract  output  1  high for '-' and low for '+', registered.
REQ-010 adder_start  output  1  one-cycle pulse; r1, r2 and subtract are valid.
REQ-011 busy  output  1  high from adder_start until the operation ends.
REQ-012 err  output  1  one-cycle pulse on a syntax error or timeout.

Function
REQ-013 The command format SHALL be HH op HH CR:
- HH = two hex ASCII digits, MSB first; '0'-'9', 'a'-'f' and 'A'-'F' are accepted.
- op = '+' (0x2B) or '-' (0x2D).
- CR = 0x0D.
REQ-014 The FSM states SHALL be A_HI, A_LO, OP, B_HI, B_LO, CR, START, WAIT; the reset state is A_HI.
REQ-015 Transitions SHALL occur only on an accepted byte (rx_vld=1):
- A_HI->A_LO->OP->B_HI->B_LO->CR->START.
REQ-016 Each digit SHALL load its nibble into a shadow register; r1, r2 and subtract SHALL update only on entry to START.
REQ-017 Space (0x20) received in any parsing state SHALL be ignored with no state change.
REQ-018 ESC (0x1B) received in any parsing state SHALL return the FSM to A_HI without an err pulse.
REQ-019 Any other unexpected byte in a parsing state SHALL:
- pulse err in the next cycle;
- return the FSM to A_HI;
- leave r1, r2 and subtract unchanged.
REQ-020 START SHALL last exactly one cycle, SHALL assert adder_start for that cycle, and SHALL then go to WAIT.
REQ-021 Timing: CR accepted at edge N gives adder_start=1 and busy=1 during cycle N+1.
REQ-022 In WAIT, adder_rdy=1 SHALL return the FSM to A_HI, with busy low on the following cycle.
REQ-023 The WAIT counter SHALL clear on entry to WAIT. When it reaches TIMEOUT with no adder_rdy, the block SHALL:
- pulse err;
- drop busy;
- return to A_HI.
REQ-024 rx_vld SHALL be ignored during START and WAIT; those bytes are dropped.
REQ-025 adder_rdy SHALL be ignored outside WAIT.
REQ-026 If adder_rdy and the timeout occur in the same cycle, adder_rdy SHALL win and err SHALL NOT pulse.
REQ-027 err and adder_start SHALL never both be high in the same cycle.

Reset
REQ-028 Gl_rst_n=0 SHALL immediately force all of the following, regardless of clk:
- FSM to A_HI;
- r1=0x00, r2=0x00, subtract=0;
- adder_start=0, busy=0, err=0;
- nibble shadows and timeout counter to 0.
REQ-029 Reset asserted mid-command or in WAIT SHALL discard the partial command, with no adder_start and no err.

Verification
REQ-030 Bench SHALL send "3A+05\r":
- adder_start pulses 1 cycle after CR, with r1=0x3A, r2=0x05, subtract=0;
- adder_rdy after 3 cycles gives busy=0 on the next cycle.
REQ-031 Bench SHALL send "ff - 01\r":
- r1=0xFF, r2=0x01, subtract=1;
- the spaces are ignored.
REQ-032 Bench SHALL send "3G":
- err pulses once, 1 cycle after 'G';
- a following "10+01\r" is parsed correctly, giving r1=0x10 and r2=0x01.
REQ-033 With TIMEOUT=8, bench SHALL send "01+01\r" and withhold adder_rdy:
- err pulses after 8 WAIT cycles, then busy=0;
- bytes sent during WAIT are dropped.
REQ-034 Bench SHALL send "12+" then ESC, then "34-56\r":
- no err;
- r1=0x34, r2=0x56, subtract=1.
REQ-035 Bench SHALL assert Gl_rst_n low asynchronously during WAIT:
- busy, r1 and r2 go to 0 before the next clk edge;
- after release, the FSM is in A_HI.
